// File: rtl/reg_bank_writer_pkg.sv
// Shared CPU register-bank definitions: sizes, register indices, FSM encoding.
package reg_bank_writer_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int NUM_REGS_DEF = 7;
  localparam int SEL_W        = 3;

  localparam logic [SEL_W-1:0] REG_A = 3'd0;
  localparam logic [SEL_W-1:0] REG_B = 3'd1;
  localparam logic [SEL_W-1:0] REG_C = 3'd2;
  localparam logic [SEL_W-1:0] REG_D = 3'd3;
  localparam logic [SEL_W-1:0] REG_E = 3'd4;
  localparam logic [SEL_W-1:0] REG_F = 3'd5;
  localparam logic [SEL_W-1:0] REG_G = 3'd6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Sweep counter width; at least one bit even for a single-register bank.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_writer_if.sv
// Write-port handshake bundle for the register bank.
interface reg_bank_writer_if
  import reg_bank_writer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             Wr_Valid;
  logic             Wr_Ready;
  logic [SEL_W-1:0] Wr_Sel;
  logic [WIDTH-1:0] Wr_Data;

  modport master (output Wr_Valid, output Wr_Sel, output Wr_Data, input  Wr_Ready);
  modport slave  (input  Wr_Valid, input  Wr_Sel, input  Wr_Data, output Wr_Ready);
endinterface

// File: rtl/reg_bank_writer_reg_sel_decoder.sv
// Turns a register select plus enable into a one-hot write-enable vector.
// Selects beyond the implemented registers raise illegal_o instead.
module reg_sel_decoder
  import reg_bank_writer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic [SEL_W-1:0]    sel_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] we_o,
  output logic                illegal_o
);

  // One-hot decode gated by the enable; illegal only for enabled out-of-range selects.
  always_comb begin
    we_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      we_o[i] = en_i && (int'(sel_i) == i);
    end
    illegal_o = en_i && (int'(sel_i) >= NUM_REGS);
  end

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the general register bank: handshaked single writes,
// a one-register-per-cycle clear sweep, and a sticky illegal-select flag.
module reg_bank_writer
  import reg_bank_writer_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter int               NUM_REGS  = NUM_REGS_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  reg_bank_writer_if.slave wr,
  input  logic             Clr_Req,
  input  logic             Err_Clr,
  output logic             Busy,
  output logic             Err,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G
);

  localparam int               CNT_W    = cnt_w(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);
  localparam int               NVIEW    = (NUM_REGS < 7) ? NUM_REGS : 7;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0]        wr_we, clr_we;
  logic                       wr_fire, wr_illegal, in_clear;
  logic [6:0][WIDTH-1:0]      view;

  assign wr_fire = wr.Wr_Valid & wr.Wr_Ready;

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_dec (
    .sel_i    (wr.Wr_Sel),
    .en_i     (wr_fire),
    .we_o     (wr_we),
    .illegal_o(wr_illegal)
  );

  // FSM state and sweep counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a clear request only matters in IDLE, so the sweep never restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Clr_Req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs from state: ready only in IDLE out of reset, clear strobe follows the counter.
  always_comb begin
    in_clear    = (state_q == ST_CLEAR);
    wr.Wr_Ready = (state_q == ST_IDLE) && Reset_n;
    clr_we      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      clr_we[i] = in_clear && (cnt_q == CNT_W'(i));
    end
  end

  // Sticky error: a new illegal write wins over a same-edge clear.
  always_comb begin
    err_d = err_q;
    if (wr_illegal)   err_d = 1'b1;
    else if (Err_Clr) err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  // Register bank; the sweep has priority, though no write is accepted while it runs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clr_we[i])     regs_q[i] <= RESET_VAL;
        else if (wr_we[i]) regs_q[i] <= wr.Wr_Data;
      end
    end
  end

  // Fixed A..G view; names not backed by a register read as RESET_VAL.
  always_comb begin
    view = {7{RESET_VAL}};
    for (int i = 0; i < NVIEW; i++) view[i] = regs_q[i];
  end

  assign A    = view[REG_A];
  assign B    = view[REG_B];
  assign C    = view[REG_C];
  assign D    = view[REG_D];
  assign E    = view[REG_E];
  assign F    = view[REG_F];
  assign G    = view[REG_G];
  assign Busy = in_clear;
  assign Err  = err_q;

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed bench for reg_bank_writer: vector table plus clear/reset sequences.
module tb_reg_bank_writer;
  import reg_bank_writer_pkg::*;

  logic       Clk, Reset_n, Clr_Req, Err_Clr, Busy, Err;
  logic [7:0] A, B, C, D, E, F, G;

  reg_bank_writer_if #(.WIDTH(8)) wif ();

  reg_bank_writer #(.WIDTH(8), .NUM_REGS(7), .RESET_VAL(8'h00)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .wr(wif), .Clr_Req(Clr_Req), .Err_Clr(Err_Clr),
    .Busy(Busy), .Err(Err), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [7:0]  data;
    logic        clr;
    logic        eclr;
    logic [55:0] regs;   // {G,F,E,D,C,B,A} after the edge
    logic        err;
    logic        busy;
    logic        rdy;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [55:0] bank();
    return {G, F, E, D, C, B, A};
  endfunction

  function automatic vec_t mk(input logic v, input logic [2:0] s, input logic [7:0] d,
                              input logic c, input logic ec, input logic [55:0] r,
                              input logic e, input logic b, input logic rd);
    vec_t t;
    t.vld = v; t.sel = s; t.data = d; t.clr = c; t.eclr = ec;
    t.regs = r; t.err = e; t.busy = b; t.rdy = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [55:0] r, input logic e,
                         input logic b, input logic rd);
    chk({tag, " regs"},  64'(bank()), 64'(r));
    chk({tag, " err"},   64'(Err), 64'(e));
    chk({tag, " busy"},  64'(Busy), 64'(b));
    chk({tag, " ready"}, 64'(wif.Wr_Ready), 64'(rd));
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d,
                       input logic c, input logic ec);
    wif.Wr_Valid = v; wif.Wr_Sel = s; wif.Wr_Data = d; Clr_Req = c; Err_Clr = ec;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  vec_t tbl[16];
  logic [6:0][7:0] m;
  int busy_cnt;

  initial begin
    // Vector table: writes A..G, illegal select, sticky error, back-to-back E writes.
    tbl[0]  = mk(1, 3'd0, 8'h10, 0, 0, 56'h00_00_00_00_00_00_10, 0, 0, 1);
    tbl[1]  = mk(1, 3'd1, 8'h11, 0, 0, 56'h00_00_00_00_00_11_10, 0, 0, 1);
    tbl[2]  = mk(1, 3'd2, 8'h12, 0, 0, 56'h00_00_00_00_12_11_10, 0, 0, 1);
    tbl[3]  = mk(1, 3'd3, 8'h13, 0, 0, 56'h00_00_00_13_12_11_10, 0, 0, 1);
    tbl[4]  = mk(1, 3'd4, 8'h14, 0, 0, 56'h00_00_14_13_12_11_10, 0, 0, 1);
    tbl[5]  = mk(1, 3'd5, 8'h15, 0, 0, 56'h00_15_14_13_12_11_10, 0, 0, 1);
    tbl[6]  = mk(1, 3'd6, 8'h16, 0, 0, 56'h16_15_14_13_12_11_10, 0, 0, 1);
    tbl[7]  = mk(1, 3'd7, 8'hFF, 0, 0, 56'h16_15_14_13_12_11_10, 1, 0, 1);
    tbl[8]  = mk(0, 3'd0, 8'h00, 0, 0, 56'h16_15_14_13_12_11_10, 1, 0, 1);
    tbl[9]  = mk(0, 3'd0, 8'h00, 0, 1, 56'h16_15_14_13_12_11_10, 0, 0, 1);
    tbl[10] = mk(1, 3'd7, 8'hFF, 0, 1, 56'h16_15_14_13_12_11_10, 1, 0, 1);
    tbl[11] = mk(0, 3'd0, 8'h00, 0, 1, 56'h16_15_14_13_12_11_10, 0, 0, 1);
    tbl[12] = mk(1, 3'd4, 8'h01, 0, 0, 56'h16_15_01_13_12_11_10, 0, 0, 1);
    tbl[13] = mk(1, 3'd4, 8'h02, 0, 0, 56'h16_15_02_13_12_11_10, 0, 0, 1);
    tbl[14] = mk(1, 3'd4, 8'h03, 0, 0, 56'h16_15_03_13_12_11_10, 0, 0, 1);
    tbl[15] = mk(1, 3'd4, 8'h14, 0, 0, 56'h16_15_14_13_12_11_10, 0, 0, 1);

    Reset_n = 1'b0;
    drive(0, 3'd0, 8'h00, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk_all("in_reset", 56'h0, 0, 0, 0);
    Reset_n = 1'b1;
    #1;
    chk_all("after_release", 56'h0, 0, 0, 1);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].clr, tbl[i].eclr);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].regs, tbl[i].err, tbl[i].busy, tbl[i].rdy);
    end

    // Clear sweep with a write held through it.
    m = 56'h16_15_14_13_12_11_10;
    drive(0, 3'd0, 8'h00, 1, 0);
    step();
    busy_cnt = 0;
    if (Busy) busy_cnt++;
    chk_all("sweep start", m, 0, 1, 0);
    drive(1, 3'd2, 8'hAA, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      m[k-1] = 8'h00;
      if (Busy) busy_cnt++;
      chk_all($sformatf("sweep k%0d", k), m, 0, (k < 7), (k == 7));
    end
    chk("sweep busy cycles", 64'(busy_cnt), 64'd7);
    step();
    m[2] = 8'hAA;
    chk_all("held write", m, 0, 0, 1);

    // Clear and write on the same edge, plus a second clear mid-sweep.
    drive(1, 3'd0, 8'h55, 1, 0);
    step();
    m[0] = 8'h55;
    busy_cnt = 0;
    if (Busy) busy_cnt++;
    chk_all("clr+write", m, 0, 1, 0);
    for (int k = 1; k <= 7; k++) begin
      drive(0, 3'd0, 8'h00, (k == 3), 0);
      step();
      m[k-1] = 8'h00;
      if (Busy) busy_cnt++;
      chk_all($sformatf("sweep2 k%0d", k), m, 0, (k < 7), (k == 7));
    end
    chk("sweep2 busy cycles", 64'(busy_cnt), 64'd7);
    drive(0, 3'd0, 8'h00, 0, 0);
    step();
    chk_all("sweep2 idle", 56'h0, 0, 0, 1);

    // Async reset in the middle of a sweep.
    drive(1, 3'd0, 8'h33, 0, 0);
    step();
    drive(1, 3'd6, 8'h77, 0, 0);
    step();
    chk_all("pre reset", 56'h77_00_00_00_00_00_33, 0, 0, 1);
    drive(0, 3'd0, 8'h00, 1, 0);
    step();
    drive(0, 3'd0, 8'h00, 0, 0);
    step();
    step();
    chk_all("mid sweep", 56'h77_00_00_00_00_00_00, 0, 1, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("async reset", 56'h0, 0, 0, 0);
    step();
    chk_all("held reset", 56'h0, 0, 0, 0);
    #2;
    Reset_n = 1'b1;
    #1;
    chk_all("post reset", 56'h0, 0, 0, 1);
    drive(1, 3'd1, 8'h42, 0, 0);
    step();
    chk_all("first write", 56'h00_00_00_00_00_42_00, 0, 0, 1);
    drive(0, 3'd0, 8'h00, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
